// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch front end and the watch block.
//   - key_state_t       : per-button debounce / long-press state
//   - IN_CLK_HZ_DEFAULT : default system clock rate (simulation scale)
//   - ms_to_cycles      : converts milliseconds to clock cycles, minimum 1
// -----------------------------------------------------------------------------
package watch_pkg;

  // 500 Hz keeps simulations short; the board runs at 50_000_000.
  localparam int IN_CLK_HZ_DEFAULT = 500;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    LONG      = 3'd3,
    DEB_REL   = 3'd4
  } key_state_t;

  // 64-bit intermediate: the board clock times a 1000 ms hold overflows 32 bits.
  function automatic int ms_to_cycles(input int hz, input int ms);
    longint cyc;
    cyc = (longint'(hz) * longint'(ms)) / 64'sd1000;
    if (cyc < 64'sd1) begin
      cyc = 64'sd1;
    end else begin
      cyc = cyc;
    end
    return int'(cyc);
  endfunction

endpackage

// File: rtl/key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
// One push-button channel: 2-FF synchroniser, polarity normalisation,
// debounce / long-press FSM and registered event outputs.
// Ports:
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   key_raw   in  raw asynchronous button pin
//   key_first out one-cycle pulse on each accepted press
//   key_long  out level, high while the press has been held LONG_CYC cycles
// -----------------------------------------------------------------------------
module key_channel
  import watch_pkg::*;
#(
  parameter int DEB_CYC    = 10,
  parameter int LONG_CYC   = 500,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_first,
  output logic key_long
);

  localparam int MAX_CYC = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic RELEASED_LVL = logic'(ACTIVE_LOW);
  // With a one-cycle debounce the first qualifying sample is already accepted.
  localparam bit DEB_ONE = (DEB_CYC <= 1);

  logic             sync_1_r, sync_2_r;
  logic             pressed_s;
  key_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic             was_long_r, was_long_s;
  logic             first_s, long_s;

  // Two-stage synchroniser; reset loads the released pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1_r <= RELEASED_LVL;
      sync_2_r <= RELEASED_LVL;
    end else begin
      sync_1_r <= key_raw;
      sync_2_r <= sync_1_r;
    end
  end

  // Normalise to pressed = 1 regardless of pin polarity.
  assign pressed_s = sync_2_r ^ RELEASED_LVL;

  // Next-state, counter and output decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    hold_cnt_s = hold_cnt_r;
    was_long_s = was_long_r;
    first_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pressed_s) begin
          if (DEB_ONE) begin
            state_s    = HELD;
            first_s    = 1'b1;
            hold_cnt_s = '0;
          end else begin
            state_s = DEB_PRESS;
            cnt_s   = CNT_ONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DEB_PRESS: begin
        if (!pressed_s) begin
          state_s = IDLE;
        end else if (cnt_r == DEB_LAST) begin
          state_s    = HELD;
          first_s    = 1'b1;
          hold_cnt_s = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        // A released sample freezes hold_cnt; it only advances on held samples.
        if (!pressed_s) begin
          state_s    = DEB_ONE ? IDLE : DEB_REL;
          cnt_s      = CNT_ONE;
          was_long_s = 1'b0;
        end else if (hold_cnt_r == LONG_LAST) begin
          state_s = LONG;
        end else begin
          hold_cnt_s = hold_cnt_r + CNT_ONE;
        end
      end
      LONG: begin
        // hold_cnt stays at LONG_LAST here, so it never wraps.
        if (!pressed_s) begin
          state_s    = DEB_ONE ? IDLE : DEB_REL;
          cnt_s      = CNT_ONE;
          was_long_s = 1'b1;
        end else begin
          state_s = LONG;
        end
      end
      DEB_REL: begin
        if (pressed_s) begin
          state_s = was_long_r ? LONG : HELD;
        end else if (cnt_r == DEB_LAST) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s    = IDLE;
        cnt_s      = '0;
        hold_cnt_s = '0;
        was_long_s = 1'b0;
      end
    endcase
    long_s = (state_s == LONG) || ((state_s == DEB_REL) && was_long_s);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      hold_cnt_r <= '0;
      was_long_r <= 1'b0;
      key_first  <= 1'b0;
      key_long   <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      hold_cnt_r <= hold_cnt_s;
      was_long_r <= was_long_s;
      key_first  <= first_s;
      key_long   <= long_s;
    end
  end

endmodule

// File: rtl/key_press_detector.sv
// -----------------------------------------------------------------------------
// key_press_detector
// Two independent debounced push-button channels feeding the watch FSM.
// Ports:
//   clk          in  system clock
//   rst_n        in  synchronous active-low reset
//   key_raw_1/2  in  raw asynchronous button pins
//   key_first_1/2 out one-cycle pulse per accepted press
//   key_long_1/2  out level, high while a press is held past LONG_CYC cycles
// -----------------------------------------------------------------------------
module key_press_detector
  import watch_pkg::*;
#(
  parameter int IN_CLK_HZ   = IN_CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_1,
  input  logic key_raw_2,
  output logic key_first_1,
  output logic key_first_2,
  output logic key_long_1,
  output logic key_long_2
);

  localparam int DEB_CYC  = ms_to_cycles(IN_CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(IN_CLK_HZ, LONG_MS);

  key_channel #(
    .DEB_CYC    (DEB_CYC),
    .LONG_CYC   (LONG_CYC),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_key_1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw_1),
    .key_first (key_first_1),
    .key_long  (key_long_1)
  );

  key_channel #(
    .DEB_CYC    (DEB_CYC),
    .LONG_CYC   (LONG_CYC),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_key_2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw_2),
    .key_first (key_first_2),
    .key_long  (key_long_2)
  );

endmodule

// File: tb/tb_key_press_detector.sv
// -----------------------------------------------------------------------------
// tb_key_press_detector
// Directed scenarios with literal expected event cycles, followed by a long
// randomized phase. A behavioural model (sample windows and run lengths)
// predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_key_press_detector;

  localparam int DEB  = 10;
  localparam int LONG = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_raw_1 = 1'b1;
  logic key_raw_2 = 1'b1;
  logic key_first_1, key_first_2, key_long_1, key_long_2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  key_press_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw_1   (key_raw_1),
    .key_raw_2   (key_raw_2),
    .key_first_1 (key_first_1),
    .key_first_2 (key_first_2),
    .key_long_1  (key_long_1),
    .key_long_2  (key_long_2)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit p1[2], p2[2], prv[2], deb[2];
  int run_p[2], run_r[2], hold[2];
  bit m_first[2], m_long[2];

  initial begin
    forever begin
      bit raw_p[2];
      bit smp;
      @(posedge clk);
      raw_p[0] = !key_raw_1;
      raw_p[1] = !key_raw_2;
      for (int ch = 0; ch < 2; ch++) begin
        if (!rst_n) begin
          p1[ch] = 1'b0; p2[ch] = 1'b0; prv[ch] = 1'b0; deb[ch] = 1'b0;
          run_p[ch] = 0; run_r[ch] = 0; hold[ch] = 0;
          m_first[ch] = 1'b0; m_long[ch] = 1'b0;
        end else begin
          smp = p2[ch];
          p2[ch] = p1[ch];
          p1[ch] = raw_p[ch];
          if (smp) begin run_p[ch]++; run_r[ch] = 0; end
          else     begin run_r[ch]++; run_p[ch] = 0; end
          m_first[ch] = 1'b0;
          if (!deb[ch]) begin
            // accepted once DEB consecutive pressed samples are seen
            if (run_p[ch] >= DEB) begin deb[ch] = 1'b1; m_first[ch] = 1'b1; hold[ch] = 0; end
          end else if (run_r[ch] >= DEB) begin
            deb[ch] = 1'b0; hold[ch] = 0;
          end else if (smp && prv[ch] && hold[ch] < LONG) begin
            // held time accrues only over back-to-back pressed samples
            hold[ch]++;
          end
          m_long[ch] = deb[ch] && (hold[ch] >= LONG);
          prv[ch] = smp;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_bit("key_first_1", key_first_1, m_first[0]);
        check_bit("key_first_2", key_first_2, m_first[1]);
        check_bit("key_long_1",  key_long_1,  m_long[0]);
        check_bit("key_long_2",  key_long_2,  m_long[1]);
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input bit exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_ev(input string name, input int q[$], input int n, input int e0, input int e1);
    check({name, " count"}, q.size(), n);
    if (n >= 1) check({name, "[0]"}, (q.size() > 0) ? q[0] : -1, e0);
    if (n >= 2) check({name, "[1]"}, (q.size() > 1) ? q[1] : -1, e1);
  endtask

  // pressed state of a button at local cycle lc for each directed scenario
  function automatic bit pressed_at(input int scn, input int ch, input int lc);
    case (scn)
      0: return (ch == 1) && (lc >= 100) && (lc <= 129);
      1: begin
        if (ch != 1) return 1'b0;
        if (lc >= 100 && lc <= 120) return (((lc - 100) / 3) % 2) == 1;
        return (lc >= 121) && (lc <= 200);
      end
      2: return (ch == 2) && (lc >= 100) && (lc <= 104);
      3: return (ch == 2) && (lc >= 100) && (lc <= 699) && !(lc >= 650 && lc <= 653);
      4: begin
        if (ch == 1) return ((lc >= 100) && (lc <= 129)) || ((lc >= 300) && (lc <= 339));
        return (lc >= 100) && (lc <= 699);
      end
      5: return (ch == 1) && (lc >= 100) && (lc <= 1299);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_scn(input int scn, input int len);
    int f1q[$], f2q[$], r1q[$], r2q[$], d1q[$], d2q[$];
    bit pl1, pl2, zero_ok;
    rst_n = 1'b0; key_raw_1 = 1'b1; key_raw_2 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    pl1 = 1'b0; pl2 = 1'b0; zero_ok = 1'b0;
    for (int lc = 0; lc <= len; lc++) begin
      if (lc > 0) begin @(posedge clk); #1; end
      if (key_first_1) f1q.push_back(lc);
      if (key_first_2) f2q.push_back(lc);
      if (key_long_1 && !pl1) r1q.push_back(lc);
      if (!key_long_1 && pl1) d1q.push_back(lc);
      if (key_long_2 && !pl2) r2q.push_back(lc);
      if (!key_long_2 && pl2) d2q.push_back(lc);
      pl1 = key_long_1; pl2 = key_long_2;
      if (lc == 651) zero_ok = !(key_first_1 | key_first_2 | key_long_1 | key_long_2);
      rst_n     = !((scn == 5) && (lc >= 650) && (lc <= 659));
      key_raw_1 = !pressed_at(scn, 1, lc);
      key_raw_2 = !pressed_at(scn, 2, lc);
    end
    case (scn)
      0: begin
        cmp_ev("clean first1", f1q, 1, 112, 0);
        cmp_ev("clean long1", r1q, 0, 0, 0);
        cmp_ev("clean first2", f2q, 0, 0, 0);
        cmp_ev("clean long2", r2q, 0, 0, 0);
      end
      1: begin
        cmp_ev("bounce first1", f1q, 1, 133, 0);
        cmp_ev("bounce long1", r1q, 0, 0, 0);
      end
      2: begin
        cmp_ev("glitch first2", f2q, 0, 0, 0);
        cmp_ev("glitch long2", r2q, 0, 0, 0);
      end
      3: begin
        cmp_ev("long first2", f2q, 1, 112, 0);
        cmp_ev("long rise2", r2q, 1, 612, 0);
        cmp_ev("long fall2", d2q, 1, 712, 0);
        cmp_ev("long first1", f1q, 0, 0, 0);
      end
      4: begin
        cmp_ev("simul first1", f1q, 2, 112, 312);
        cmp_ev("simul first2", f2q, 1, 112, 0);
        cmp_ev("simul rise2", r2q, 1, 612, 0);
        cmp_ev("simul fall2", d2q, 1, 712, 0);
        cmp_ev("simul long1", r1q, 0, 0, 0);
      end
      5: begin
        check("reset clears outputs", int'(zero_ok), 1);
        cmp_ev("reset first1", f1q, 2, 112, 672);
        cmp_ev("reset rise1", r1q, 2, 612, 1172);
        cmp_ev("reset fall1", d1q, 2, 651, 1312);
      end
      default: ;
    endcase
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(99, 0);
    if (r < 55) return $urandom_range(12, 1);
    if (r < 90) return $urandom_range(60, 8);
    return $urandom_range(700, 400);
  endfunction

  task automatic rand_phase(input int cycles);
    bit lvl[2];
    int left[2];
    int rst_left;
    lvl[0] = 1'b0; lvl[1] = 1'b0;
    left[0] = pick_len(); left[1] = pick_len();
    rst_left = 0;
    rst_n = 1'b1; key_raw_1 = 1'b1; key_raw_2 = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int ch = 0; ch < 2; ch++) begin
        left[ch]--;
        if (left[ch] <= 0) begin
          lvl[ch] = !lvl[ch];
          left[ch] = pick_len();
        end
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(3999, 0) == 0) rst_left = $urandom_range(3, 1);
      rst_n     = (rst_left == 0);
      key_raw_1 = !lvl[0];
      key_raw_2 = !lvl[1];
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk_en = 1'b1;
    for (int s = 0; s < 6; s++) begin
      run_scn(s, (s == 5) ? 1350 : ((s == 3 || s == 4) ? 900 : 300));
    end
    rand_phase(20000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
